// File: rtl/sram_port_pkg.sv
// Shared definitions for the requester-side SRAM array drivers.
// Holds the default geometry of the 8x30 masked macro, the derived lane and
// counter widths, and the request bundle layout used by sibling drivers.
package sram_port_pkg;

  localparam int DEF_ADDR_W     = 3;
  localparam int DEF_DATA_W     = 30;
  localparam int DEF_MASK_SEG   = 2;
  localparam int DEF_RESP_DEPTH = 3;

  localparam int LANE_W = DEF_DATA_W / DEF_MASK_SEG;
  localparam int CNT_W  = $clog2(DEF_RESP_DEPTH + 1);

  // Counter width able to hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic                    write;
    logic [DEF_ADDR_W-1:0]   addr;
    logic [DEF_MASK_SEG-1:0] mask;
    logic [DEF_DATA_W-1:0]   data;
  } sram_req_t;

endpackage

// File: rtl/sram_resp_fifo.sv
// Small circular response FIFO for captured SRAM read data.
// Ports:
//   clock, reset        clock and asynchronous active-high reset
//   push, push_data     write one entry at the tail
//   pop                 drop the head entry (ignored when empty)
//   pop_data            current head entry
//   full, empty, count  occupancy status
// Push and pop may occur together at any occupancy, including full: the head
// is read combinationally before the tail slot is overwritten at the edge.
module sram_resp_fifo
  import sram_port_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int RESP_DEPTH = DEF_RESP_DEPTH
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             push,
  input  logic [DATA_W-1:0]                push_data,
  input  logic                             pop,
  output logic [DATA_W-1:0]                pop_data,
  output logic                             full,
  output logic                             empty,
  output logic [cnt_width(RESP_DEPTH)-1:0] count
);

  localparam int CW = cnt_width(RESP_DEPTH);
  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(RESP_DEPTH - 1);

  logic [DATA_W-1:0] store [RESP_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              pop_en;

  assign pop_en   = pop && !empty;
  assign pop_data = store[rd_ptr];
  assign full     = (count == CW'(RESP_DEPTH));
  assign empty    = (count == '0);

  // Pointers wrap at RESP_DEPTH, which need not be a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
      if (pop_en) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
      case ({push, pop_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; only the pointers define validity.
  always_ff @(posedge clock) begin
    if (push) store[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/sram_rw_port_driver.sv
// Requester-side driver for a single-port masked SRAM macro.
// Ports:
//   clock, reset                  clock (also the macro clock), async active-high reset
//   req_valid/req_ready           request handshake; req_write/addr/mask/data payload
//   resp_valid/resp_ready         read response handshake; resp_data in request order
//   mem_en/wmode/addr/wmask/wdata macro pins, driven combinationally from the request
//   mem_rdata                     macro read data, valid the cycle after a read fire
// A request is only accepted when a response slot is guaranteed, counting the
// read still in flight, so the FIFO can never overflow.
module sram_rw_port_driver
  import sram_port_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MASK_SEG   = DEF_MASK_SEG,
  parameter int RESP_DEPTH = DEF_RESP_DEPTH
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [MASK_SEG-1:0] req_mask,
  input  logic [DATA_W-1:0]   req_data,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_data,
  output logic                mem_en,
  output logic                mem_wmode,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [MASK_SEG-1:0] mem_wmask,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int CW = cnt_width(RESP_DEPTH);
  localparam logic [CW:0] DEPTH_V = (CW + 1)'(RESP_DEPTH);

  logic          fire;
  logic          rd_pend;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   occupancy;

  // Slots already promised: stored responses plus the read whose data arrives
  // next cycle. Depends only on state and reset, never on resp_ready.
  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, rd_pend};
  assign req_ready = !reset && !fifo_full && (occupancy < DEPTH_V);
  assign fire      = req_valid && req_ready;

  // A fully masked write is accepted but never touches the array.
  assign mem_en    = fire && !(req_write && (req_mask == '0));
  assign mem_wmode = req_write;
  assign mem_addr  = req_addr;
  assign mem_wmask = req_write ? req_mask : '0;
  assign mem_wdata = req_data;

  // The macro output is only meaningful the cycle after the read fires, so
  // rd_pend marks exactly that cycle for capture.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) rd_pend <= 1'b0;
    else       rd_pend <= fire && !req_write;
  end

  assign resp_valid = !fifo_empty;

  sram_resp_fifo #(
    .DATA_W     (DATA_W),
    .RESP_DEPTH (RESP_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (rd_pend),
    .push_data (mem_rdata),
    .pop       (resp_valid && resp_ready),
    .pop_data  (resp_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule
